lrck_mix_scheduler: RTL and testbench

//  Per-half-frame mix scheduler for the WM8731 left-channel path. Time-multiplexes NREQ effect sources

---
 rtl/lrck_mix_scheduler_pkg.sv | 21 ++
 rtl/lrck_mix_scheduler_mix_saturate.sv | 20 ++
 rtl/lrck_mix_scheduler.sv | 97 +++++++++
 tb/tb_lrck_mix_scheduler.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/lrck_mix_scheduler_pkg.sv
// Shared definitions for the LRCK-phase mix scheduler: FSM encodings, width defaults,
// clog2 helper and the half-frame slot budget.
package lrck_mix_scheduler_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int WS_DEFAULT  = 16;
    localparam int SLOT_BUDGET = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/lrck_mix_scheduler_mix_saturate.sv
// Combinational clamp of a wide signed sum into WS bits, flagging when the clamp bites.
module mix_saturate #(
    parameter int WS   = 16,
    parameter int ACCW = 18
) (
    input  logic [ACCW-1:0] din,
    output logic [WS-1:0]   dout,
    output logic            clip
);
    // In range exactly when every bit above the result's sign bit matches it.
    logic [ACCW-WS:0] hi;
    assign hi = din[ACCW-1:WS-1];

    always_comb begin
        clip = !((hi == '0) || (hi == '1));
        dout = din[WS-1:0];
        if (clip)
            dout = din[ACCW-1] ? {1'b1, {(WS-1){1'b0}}} : {1'b0, {(WS-1){1'b1}}};
    end
endmodule

// File: rtl/lrck_mix_scheduler.sv
// Half-frame mix scheduler: scans NREQ sources over a shared read bus while ADCLRCK is low,
// sums, shifts and (with MIX_SAT_EN defined) clamps the result into one mixed sample.
module lrck_mix_scheduler
    import lrck_mix_scheduler_pkg::*;
#(
    parameter int WS    = WS_DEFAULT,
    parameter int NREQ  = 4,
    parameter int SHIFT = 0,
    parameter int LOGN  = clog2(NREQ),
    parameter int SELW  = (LOGN < 1) ? 1 : LOGN,
    parameter int ACCW  = WS + LOGN
) (
    input  logic            AUD_BCLK,
    input  logic            AUD_ADCLRCK,
    input  logic [NREQ-1:0] i_en,
    input  logic [NREQ-1:0] i_rdy,
    input  logic [WS-1:0]   i_rdata,
    output logic [SELW-1:0] o_sel,
    output logic [NREQ-1:0] o_ack,
    output logic [WS-1:0]   o_mix,
    output logic            o_valid,
    output logic            o_clip,
    output logic [7:0]      o_miss,
    output logic            o_busy
);
    logic [1:0]             state;
    logic [SELW-1:0]        idx;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] shifted;
    logic [WS-1:0]          mix_next;
    logic                   clip_next;
    logic                   hit;
    logic                   miss;
    logic                   scan;

    assign scan = (state == ST_SCAN);
    assign hit  = scan && i_en[idx] && i_rdy[idx];
    assign miss = scan && i_en[idx] && !i_rdy[idx];

    assign shifted = acc >>> SHIFT;

`ifdef MIX_SAT_EN
    mix_saturate #(.WS(WS), .ACCW(ACCW)) u_sat (
        .din  (shifted),
        .dout (mix_next),
        .clip (clip_next)
    );
`else
    assign mix_next  = shifted[WS-1:0];
    assign clip_next = 1'b0;
`endif

    always_comb begin
        o_ack = '0;
        if (hit) o_ack[idx] = 1'b1;
    end

    assign o_sel  = scan ? idx : '0;
    assign o_busy = scan || (state == ST_NORM);

    always_ff @(posedge AUD_BCLK or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
            state   <= ST_IDLE;
            idx     <= '0;
            acc     <= '0;
            o_mix   <= '0;
            o_valid <= 1'b0;
            o_clip  <= 1'b0;
            o_miss  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    acc    <= '0;
                    idx    <= '0;
                    o_miss <= '0;
                    state  <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (hit) acc <= acc + ACCW'(signed'(i_rdata));
                    if (miss && o_miss != 8'hFF) o_miss <= o_miss + 8'd1;
                    idx <= idx + 1'b1;
                    if (idx == SELW'(NREQ - 1)) state <= ST_NORM;
                end
                ST_NORM: begin
                    o_mix   <= mix_next;
                    o_clip  <= clip_next;
                    o_valid <= 1'b1;
                    state   <= ST_DONE;
                end
                default: begin
                    // Result stays parked until the next high phase of ADCLRCK.
                    o_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lrck_mix_scheduler.sv
// Directed table-driven bench: one SHIFT=0 and one SHIFT=2 instance share clock, reset and masks.
module tb_lrck_mix_scheduler;

    logic        aud_bclk = 1'b0;
    logic        aud_adclrck = 1'b1;
    logic [3:0]  en = '0;
    logic [3:0]  rdy = '0;
    logic [3:0][15:0] cur_a = '0;
    logic [3:0][15:0] cur_b = '0;

    logic [15:0] rdata_a, rdata_b, mix_a, mix_b;
    logic [1:0]  sel_a, sel_b;
    logic [3:0]  ack_a, ack_b;
    logic        valid_a, valid_b, clip_a, clip_b, busy_a, busy_b;
    logic [7:0]  miss_a, miss_b;

    int checks = 0;
    int errors = 0;

    always #5 aud_bclk = ~aud_bclk;

    always_comb rdata_a = cur_a[sel_a];
    always_comb rdata_b = cur_b[sel_b];

    lrck_mix_scheduler #(.WS(16), .NREQ(4), .SHIFT(0)) dut_a (
        .AUD_BCLK(aud_bclk), .AUD_ADCLRCK(aud_adclrck), .i_en(en), .i_rdy(rdy),
        .i_rdata(rdata_a), .o_sel(sel_a), .o_ack(ack_a), .o_mix(mix_a),
        .o_valid(valid_a), .o_clip(clip_a), .o_miss(miss_a), .o_busy(busy_a)
    );

    lrck_mix_scheduler #(.WS(16), .NREQ(4), .SHIFT(2)) dut_b (
        .AUD_BCLK(aud_bclk), .AUD_ADCLRCK(aud_adclrck), .i_en(en), .i_rdy(rdy),
        .i_rdata(rdata_b), .o_sel(sel_b), .o_ack(ack_b), .o_mix(mix_b),
        .o_valid(valid_b), .o_clip(clip_b), .o_miss(miss_b), .o_busy(busy_b)
    );

    typedef struct {
        string            name;
        logic [3:0]       en;
        logic [3:0]       rdy;
        logic [3:0][15:0] da;
        logic [3:0][15:0] db;
        logic [15:0]      mix_a;
        logic [15:0]      mix_b;
        logic             clip;
        logic [7:0]       miss;
    } vec_t;

    vec_t vecs[6];

`ifdef MIX_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] exp_ack;
        aud_adclrck = 1'b1;
        en = v.en; rdy = v.rdy; cur_a = v.da; cur_b = v.db;
        repeat (2) @(negedge aud_bclk);
        chk({v.name, " rst mix"},   32'(mix_a), 32'h0);
        chk({v.name, " rst valid"}, 32'(valid_a), 32'h0);
        chk({v.name, " rst busy"},  32'(busy_a), 32'h0);
        chk({v.name, " rst miss"},  32'(miss_a), 32'h0);
        chk({v.name, " rst clip"},  32'(clip_a), 32'h0);
        chk({v.name, " rst ack"},   32'(ack_a), 32'h0);
        aud_adclrck = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge aud_bclk);
            @(negedge aud_bclk);
            exp_ack = '0;
            if (c <= 4 && v.en[c-1] && v.rdy[c-1]) exp_ack[c-1] = 1'b1;
            chk($sformatf("%s ack a e%0d", v.name, c), 32'(ack_a), 32'(exp_ack));
            chk($sformatf("%s ack b e%0d", v.name, c), 32'(ack_b), 32'(exp_ack));
            chk($sformatf("%s valid a e%0d", v.name, c), 32'(valid_a), 32'(c == 6));
            chk($sformatf("%s valid b e%0d", v.name, c), 32'(valid_b), 32'(c == 6));
            chk($sformatf("%s busy e%0d", v.name, c), 32'(busy_a), 32'(c <= 5));
            if (c <= 4) chk($sformatf("%s sel e%0d", v.name, c), 32'(sel_a), 32'(c - 1));
            if (c >= 6) begin
                chk($sformatf("%s mix a e%0d", v.name, c), 32'(mix_a), 32'(v.mix_a));
                chk($sformatf("%s mix b e%0d", v.name, c), 32'(mix_b), 32'(v.mix_b));
                chk($sformatf("%s clip e%0d", v.name, c), 32'(clip_a), 32'(v.clip));
                chk($sformatf("%s clip b e%0d", v.name, c), 32'(clip_b), 32'h0);
                chk($sformatf("%s miss a e%0d", v.name, c), 32'(miss_a), 32'(v.miss));
                chk($sformatf("%s miss b e%0d", v.name, c), 32'(miss_b), 32'(v.miss));
                chk($sformatf("%s sel done e%0d", v.name, c), 32'(sel_a), 32'h0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{"basic", 4'hF, 4'hF, {16'd25, 16'(-50), 16'd200, 16'd100},
                    {16'd400, 16'd400, 16'd400, 16'd400}, 16'd275, 16'd400, 1'b0, 8'd0};
        vecs[1] = '{"notrdy", 4'hF, 4'hB, {16'd25, 16'(-50), 16'd200, 16'd100},
                    {16'd0, 16'd0, 16'd0, 16'(-3)}, 16'd325, 16'hFFFF, 1'b0, 8'd1};
        vecs[2] = '{"pos big", 4'hF, 4'hF, {4{16'd16000}}, '0,
                    SAT ? 16'h7FFF : 16'hFA00, 16'h0, SAT, 8'd0};
        vecs[3] = '{"neg big", 4'hF, 4'hF, {4{16'(-16000)}}, '0,
                    SAT ? 16'h8000 : 16'h0600, 16'h0, SAT, 8'd0};
        vecs[4] = '{"none en", 4'h0, 4'hF, {16'd9, 16'd9, 16'd9, 16'd9}, '0,
                    16'h0, 16'h0, 1'b0, 8'd0};
        vecs[5] = '{"mixed", 4'b0101, 4'b0011, {16'd1000, 16'd1000, 16'd1000, 16'd7}, '0,
                    16'd7, 16'h0, 1'b0, 8'd1};

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Abort mid-scan: async clear, no valid while held, then a clean rerun.
        aud_adclrck = 1'b1;
        en = vecs[0].en; rdy = vecs[0].rdy; cur_a = vecs[0].da; cur_b = vecs[0].db;
        repeat (2) @(negedge aud_bclk);
        aud_adclrck = 1'b0;
        repeat (3) @(posedge aud_bclk);
        #1;
        chk("abort busy before", 32'(busy_a), 32'h1);
        aud_adclrck = 1'b1;
        #1;
        chk("abort busy", 32'(busy_a), 32'h0);
        chk("abort mix",  32'(mix_a), 32'h0);
        chk("abort sel",  32'(sel_a), 32'h0);
        chk("abort ack",  32'(ack_a), 32'h0);
        chk("abort miss", 32'(miss_a), 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge aud_bclk);
            chk($sformatf("abort valid %0d", c), 32'(valid_a | valid_b), 32'h0);
        end
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
